// File: rtl/debounce_scheduler_if.sv
// Button bus between the raw push-button pins and the debounced outputs
// used by the game logic. The design side takes the slave modport.
interface debounce_scheduler_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_state;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             scan_busy;

    modport master (
        output btn_raw,
        input  btn_state,
        input  btn_press,
        input  btn_release,
        input  scan_busy
    );

    modport slave (
        input  btn_raw,
        output btn_state,
        output btn_press,
        output btn_release,
        output scan_busy
    );
endinterface

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N_BTN buttons with one shared evaluation engine.
// A prescaler tick starts a scan that visits one button per clock and updates that
// button's stability counter. Optional macro AUTO_REPEAT_EN adds held-button
// auto-repeat press pulses.
module debounce_scheduler #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned STABLE_CNT    = 4,
    parameter int unsigned REPEAT_DELAY  = 32,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    debounce_scheduler_if.slave bus
);

    localparam int unsigned      IdxW     = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned      PreW     = $clog2(TICK_DIV);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N_BTN - 1);
    localparam logic [PreW-1:0]  PreMax   = PreW'(TICK_DIV - 1);
    // cnt+1 == STABLE_CNT is tested as cnt == STABLE_CNT-1 to keep it 4 bits wide
    localparam logic [3:0]       StableM1 = 4'(STABLE_CNT - 1);

    // Elaboration-time parameter sanity checks
    if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n_btn
        $error("debounce_scheduler: N_BTN must be 1..16");
    end
    if (TICK_DIV < N_BTN + 2) begin : g_bad_tick_div
        $error("debounce_scheduler: TICK_DIV must be >= N_BTN+2");
    end
    if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable
        $error("debounce_scheduler: STABLE_CNT must be 1..15");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("debounce_scheduler: REPEAT_PERIOD must be 1..REPEAT_DELAY");
    end

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [PreW-1:0]  r_presc;
    state_e           r_fsm;
    logic [IdxW-1:0]  r_idx;
    logic [N_BTN-1:0] r_snap;
    logic [N_BTN-1:0] r_state;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [3:0]       r_cnt [N_BTN];

    logic             w_tick;
    logic             w_cur_snap;
    logic             w_cur_state;
    logic [3:0]       w_cur_cnt;
    logic             w_accept;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned     RepW      = $clog2(REPEAT_DELAY + 1);
    // rep+1 == REPEAT_DELAY means the hold counter is reaching the delay now
    localparam logic [RepW-1:0] RepLast   = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RepW-1:0] r_rep [N_BTN];
`endif

    // Two-flop synchronizer on the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample prescaler; keeps counting while a scan is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_presc == PreMax) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Tick strobe and the view of the button currently being evaluated
    always_comb begin
        w_tick      = (r_presc == PreMax);
        w_cur_snap  = r_snap[r_idx];
        w_cur_state = r_state[r_idx];
        w_cur_cnt   = r_cnt[r_idx];
        w_accept    = (w_cur_snap != w_cur_state) && (w_cur_cnt == StableM1);
    end

    // Scan FSM with the per-button evaluation and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= StIdle;
            r_idx     <= '0;
            r_snap    <= '0;
            r_state   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
`ifdef AUTO_REPEAT_EN
                r_rep[i] <= '0;
`endif
            end
        end else begin
            r_press   <= '0;
            r_release <= '0;
            case (r_fsm)
                StIdle: begin
                    if (w_tick) begin
                        // One coherent snapshot serves the whole scan
                        r_snap <= r_sync2;
                        r_idx  <= '0;
                        r_fsm  <= StScan;
                    end
                end
                StScan: begin
                    // Ticks seen here are dropped; only reachable with a bad TICK_DIV
                    if (w_cur_snap == w_cur_state) begin
                        r_cnt[r_idx] <= '0;
                    end else if (w_accept) begin
                        r_state[r_idx]   <= w_cur_snap;
                        r_cnt[r_idx]     <= '0;
                        r_press[r_idx]   <= w_cur_snap;
                        r_release[r_idx] <= ~w_cur_snap;
                    end else begin
                        r_cnt[r_idx] <= w_cur_cnt + 4'd1;
                    end
`ifdef AUTO_REPEAT_EN
                    // Hold counter restarts on either accepted edge, runs while held
                    if (w_accept) begin
                        r_rep[r_idx] <= '0;
                    end else if (w_cur_state) begin
                        if (r_rep[r_idx] == RepLast) begin
                            r_rep[r_idx]   <= RepReload;
                            r_press[r_idx] <= 1'b1;
                        end else begin
                            r_rep[r_idx] <= r_rep[r_idx] + 1'b1;
                        end
                    end
`endif
                    if (r_idx == LastIdx) begin
                        r_fsm <= StIdle;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_fsm <= StIdle;
            endcase
        end
    end

    assign bus.btn_state   = r_state;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.scan_busy   = (r_fsm == StScan);

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler (N_BTN=4, TICK_DIV=8, STABLE_CNT=3).
// Outputs are compared every cycle against a per-tick reference model; directed
// phases add pulse-count and timing checks. Build with AUTO_REPEAT_EN to cover repeat.
module tb_debounce_scheduler;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int SC = 3;
    localparam int RD = 4;
    localparam int RP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    debounce_scheduler_if #(.N_BTN(N)) bus ();

    debounce_scheduler #(
        .N_BTN        (N),
        .TICK_DIV     (TD),
        .STABLE_CNT   (SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         edge_n;
    logic [N-1:0] m_s1, m_s2;
    logic [N-1:0] m_state;
    logic [N-1:0] vis_state, vis_press, vis_rel;
    int         m_run [N];
    int         sch_edge [N];
    logic       sch_state [N];
    logic       sch_press [N];
    logic       sch_rel [N];
`ifdef AUTO_REPEAT_EN
    int         m_hold [N];
`endif

    // Observed pulse bookkeeping
    int press_cnt [N];
    int rel_cnt [N];
    int last_press_edge [N];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i]       = 0;
            rel_cnt[i]         = 0;
            last_press_edge[i] = -1;
        end
    endtask

    task automatic model_reset();
        edge_n    = 0;
        m_s1      = '0;
        m_s2      = '0;
        m_state   = '0;
        vis_state = '0;
        vis_press = '0;
        vis_rel   = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i]     = 0;
            sch_edge[i]  = -1;
            sch_state[i] = 1'b0;
            sch_press[i] = 1'b0;
            sch_rel[i]   = 1'b0;
`ifdef AUTO_REPEAT_EN
            m_hold[i]    = 0;
`endif
        end
        clear_counts();
    endtask

    // One sample tick: decide every button now, results appear at edge+1+i
    task automatic do_tick(input logic [N-1:0] smp);
        for (int i = 0; i < N; i++) begin
            logic p;
            logic r;
            p = 1'b0;
            r = 1'b0;
            if (smp[i] != m_state[i] && m_run[i] + 1 == SC) begin
                m_state[i] = smp[i];
                m_run[i]   = 0;
                p          = smp[i];
                r          = ~smp[i];
`ifdef AUTO_REPEAT_EN
                m_hold[i]  = 0;
`endif
            end else begin
                m_run[i] = (smp[i] == m_state[i]) ? 0 : m_run[i] + 1;
`ifdef AUTO_REPEAT_EN
                if (m_state[i]) begin
                    m_hold[i]++;
                    if (m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) p = 1'b1;
                end
`endif
            end
            sch_edge[i]  = edge_n + 1 + i;
            sch_state[i] = m_state[i];
            sch_press[i] = p;
            sch_rel[i]   = r;
        end
    endtask

    // Advance one clock, update the model, then compare on the falling edge
    task automatic step();
        logic [N-1:0] smp;
        @(posedge clk);
        edge_n++;
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.btn_raw;
        if (edge_n % TD == 0) do_tick(smp);
        vis_press = '0;
        vis_rel   = '0;
        for (int i = 0; i < N; i++) begin
            if (sch_edge[i] == edge_n) begin
                vis_state[i] = sch_state[i];
                vis_press[i] = sch_press[i];
                vis_rel[i]   = sch_rel[i];
                sch_edge[i]  = -1;
            end
        end
        @(negedge clk);
        check("state", 16'(bus.btn_state), 16'(vis_state));
        check("press", 16'(bus.btn_press), 16'(vis_press));
        check("release", 16'(bus.btn_release), 16'(vis_rel));
        check("busy", 16'(bus.scan_busy),
              16'((edge_n >= TD) && (edge_n % TD < N)));
        for (int i = 0; i < N; i++) begin
            if (bus.btn_press[i] === 1'b1) begin
                press_cnt[i]++;
                last_press_edge[i] = edge_n;
            end
            if (bus.btn_release[i] === 1'b1) rel_cnt[i]++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_state"}, 16'(bus.btn_state), 16'h0);
        check({tag, "_press"}, 16'(bus.btn_press), 16'h0);
        check({tag, "_release"}, 16'(bus.btn_release), 16'h0);
        check({tag, "_busy"}, 16'(bus.scan_busy), 16'h0);
    endtask

    initial begin
        int guard;
        int total;
        bus.btn_raw = '0;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Idle: no pulses for 200 cycles, busy pattern checked every cycle
        repeat (200) step();
        total = 0;
        for (int i = 0; i < N; i++) total += press_cnt[i] + rel_cnt[i];
        check("idle_pulses", 16'(total), 16'd0);

        // Single press on button 0
        clear_counts();
        bus.btn_raw[0] = 1'b1;
        repeat (40) step();
        check("b0_press_cnt", 16'(press_cnt[0]), 16'd1);
        check("b0_rel_cnt", 16'(rel_cnt[0]), 16'd0);

        // Bouncing button 1: never more than two consecutive high samples
        clear_counts();
        for (int c = 0; c < 240; c++) begin
            bus.btn_raw[1] = ((c % 24) < 12);
            step();
        end
        bus.btn_raw[1] = 1'b0;
        check("b1_state", 16'(bus.btn_state[1]), 16'd0);
        check("b1_pulses", 16'(press_cnt[1] + rel_cnt[1]), 16'd0);

        // Buttons 0 and 3 rise together: same scan, presses 3 cycles apart
        bus.btn_raw[0] = 1'b0;
        repeat (60) step();
        clear_counts();
        bus.btn_raw[0] = 1'b1;
        bus.btn_raw[3] = 1'b1;
        repeat (40) step();
        check("b0_pair_cnt", 16'(press_cnt[0]), 16'd1);
        check("b3_pair_cnt", 16'(press_cnt[3]), 16'd1);
        check("pair_gap", 16'(last_press_edge[3] - last_press_edge[0]), 16'd3);
        clear_counts();
        bus.btn_raw[0] = 1'b0;
        repeat (40) step();
        check("b0_rel_once", 16'(rel_cnt[0]), 16'd1);
        check("b0_state_low", 16'(bus.btn_state[0]), 16'd0);

        // Reset during a scan with button 2 two samples into a change
        clear_counts();
        bus.btn_raw[2] = 1'b1;
        guard = 0;
        while (m_run[2] != 2 && guard < 100) begin
            step();
            guard++;
        end
        check("b2_pending", 16'(m_run[2]), 16'd2);
        guard = 0;
        do begin
            step();
            guard++;
        end while (edge_n % TD != 0 && guard < 20);
        check("midscan_busy", 16'(bus.scan_busy), 16'd1);
        check("b2_no_early", 16'(press_cnt[2]), 16'd0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midscan");
        repeat (2) @(negedge clk);
        check_outputs_zero("midscan_hold");
        rst_n = 1'b1;
        model_reset();
        guard = 0;
        while (press_cnt[2] == 0 && guard < 60) begin
            step();
            guard++;
        end
        // sync (2) + ticks at 8,16,24 + index 2 + 1
        check("b2_after_reset_edge", 16'(last_press_edge[2]), 16'd27);
        check("b2_after_reset_cnt", 16'(press_cnt[2]), 16'd1);

        // Random activity against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) begin
                int b;
                b = int'($urandom_range(N - 1));
                bus.btn_raw[b] = ~bus.btn_raw[b];
            end
            step();
        end

        // Long hold on button 2: repeat pulses only when the feature is built in
        bus.btn_raw = '0;
        repeat (60) step();
        clear_counts();
        bus.btn_raw[2] = 1'b1;
        guard = 0;
        while (press_cnt[2] == 0 && guard < 60) begin
            step();
            guard++;
        end
        check("hold_accept", 16'(press_cnt[2]), 16'd1);
        clear_counts();
        repeat (8 * TD) step();
`ifdef AUTO_REPEAT_EN
        check("hold_repeats", 16'(press_cnt[2]), 16'd3);
`else
        check("hold_repeats", 16'(press_cnt[2]), 16'd0);
`endif
        clear_counts();
        bus.btn_raw[2] = 1'b0;
        repeat (60) step();
        check("hold_release", 16'(rel_cnt[2]), 16'd1);
        check("hold_stop", 16'(press_cnt[2]), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
